// File: rtl/wb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : wb_ram_arbiter
// Brief   : Two-master Wishbone B3 round-robin arbiter in front of the on-chip
//           RAM slave. The grant is held for the whole cycle. Define
//           WB_RAM_ARBITER_WATCHDOG_EN to add a stalled-strobe watchdog.
// Revision: 1.0 - initial release
// ============================================================================
module wb_ram_arbiter #(
  parameter int DW        = 32,
  parameter int AW        = 32,
  parameter int WD_CYCLES = 256
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_n_i,
  input  logic [AW-1:0] m0_adr_i,
  input  logic [DW-1:0] m0_dat_i,
  input  logic [3:0]    m0_sel_i,
  input  logic          m0_we_i,
  input  logic [1:0]    m0_bte_i,
  input  logic [2:0]    m0_cti_i,
  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  output logic [DW-1:0] m0_dat_o,
  output logic          m0_ack_o,
  output logic          m0_err_o,
  output logic          m0_rty_o,
  input  logic [AW-1:0] m1_adr_i,
  input  logic [DW-1:0] m1_dat_i,
  input  logic [3:0]    m1_sel_i,
  input  logic          m1_we_i,
  input  logic [1:0]    m1_bte_i,
  input  logic [2:0]    m1_cti_i,
  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  output logic [DW-1:0] m1_dat_o,
  output logic          m1_ack_o,
  output logic          m1_err_o,
  output logic          m1_rty_o,
  output logic [AW-1:0] s_adr_o,
  output logic [DW-1:0] s_dat_o,
  output logic [3:0]    s_sel_o,
  output logic          s_we_o,
  output logic [1:0]    s_bte_o,
  output logic [2:0]    s_cti_o,
  output logic          s_cyc_o,
  output logic          s_stb_o,
  input  logic [DW-1:0] s_dat_i,
  input  logic          s_ack_i,
  input  logic          s_err_i,
  input  logic          s_rty_i,
  output logic [1:0]    gnt_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GNT0 = 2'd1;
  localparam logic [1:0] ST_GNT1 = 2'd2;

  logic [1:0] state_q, state_d;
  logic       last_gnt_q, last_gnt_d;
  logic       wd_fire;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q    <= ST_IDLE;
      last_gnt_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_d = last_gnt_q ? ST_GNT0 : ST_GNT1;
        end else if (m0_cyc_i) begin
          state_d = ST_GNT0;
        end else if (m1_cyc_i) begin
          state_d = ST_GNT1;
        end
      end
      // On release, hand over directly to a waiting master with no idle cycle.
      ST_GNT0: if (!m0_cyc_i) state_d = m1_cyc_i ? ST_GNT1 : ST_IDLE;
      ST_GNT1: if (!m1_cyc_i) state_d = m0_cyc_i ? ST_GNT0 : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    last_gnt_d = last_gnt_q;
    if (state_d == ST_GNT0) begin
      last_gnt_d = 1'b0;
    end else if (state_d == ST_GNT1) begin
      last_gnt_d = 1'b1;
    end
  end

`ifdef WB_RAM_ARBITER_WATCHDOG_EN
  localparam int WD_W = $clog2(WD_CYCLES) + 1;

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            wd_stalled;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end

  always_comb begin
    wd_stalled = 1'b0;
    case (state_q)
      ST_GNT0: wd_stalled = m0_stb_i;
      ST_GNT1: wd_stalled = m1_stb_i;
      default: wd_stalled = 1'b0;
    endcase
    wd_stalled = wd_stalled & ~(s_ack_i | s_err_i | s_rty_i);
    wd_fire    = wd_stalled && (wd_cnt_q == WD_W'(WD_CYCLES - 1));
    if (!wd_stalled || wd_fire || (state_d != state_q)) begin
      wd_cnt_d = '0;
    end else begin
      wd_cnt_d = wd_cnt_q + WD_W'(1);
    end
  end
`else
  logic unused_wd;
  assign unused_wd = ^WD_CYCLES;
  assign wd_fire   = 1'b0;
`endif

  // Slave side is purely combinational from the grant, so reset isolates it at once.
  always_comb begin
    s_adr_o  = m0_adr_i;
    s_dat_o  = m0_dat_i;
    s_sel_o  = m0_sel_i;
    s_bte_o  = m0_bte_i;
    s_we_o   = 1'b0;
    s_cti_o  = 3'b000;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m0_rty_o = 1'b0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    m1_rty_o = 1'b0;
    gnt_o    = 2'b00;
    case (state_q)
      ST_GNT0: begin
        s_we_o   = m0_we_i;
        s_cti_o  = m0_cti_i;
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i & ~wd_fire;
        m0_ack_o = s_ack_i;
        m0_err_o = s_err_i | wd_fire;
        m0_rty_o = s_rty_i;
        gnt_o    = 2'b01;
      end
      ST_GNT1: begin
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        s_bte_o  = m1_bte_i;
        s_we_o   = m1_we_i;
        s_cti_o  = m1_cti_i;
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i & ~wd_fire;
        m1_ack_o = s_ack_i;
        m1_err_o = s_err_i | wd_fire;
        m1_rty_o = s_rty_i;
        gnt_o    = 2'b10;
      end
      default: ;
    endcase
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

endmodule
`default_nettype wire

// File: tb/tb_wb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_wb_ram_arbiter
// Brief   : Directed and random stimulus for wb_ram_arbiter, checked against
//           an ownership/round-robin reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_wb_ram_arbiter;

  localparam int WD = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] m_adr [2];
  logic [31:0] m_dat [2];
  logic [3:0]  m_sel [2];
  logic        m_we  [2];
  logic [1:0]  m_bte [2];
  logic [2:0]  m_cti [2];
  logic        m_cyc [2];
  logic        m_stb [2];
  logic [31:0] s_dat_i;
  logic        s_ack_i, s_err_i, s_rty_i;

  logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
  logic        m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o;
  logic [3:0]  s_sel_o;
  logic        s_we_o, s_cyc_o, s_stb_o;
  logic [1:0]  s_bte_o, gnt_o;
  logic [2:0]  s_cti_o;

  wb_ram_arbiter #(.DW(32), .AW(32), .WD_CYCLES(WD)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .m0_adr_i(m_adr[0]), .m0_dat_i(m_dat[0]), .m0_sel_i(m_sel[0]), .m0_we_i(m_we[0]),
    .m0_bte_i(m_bte[0]), .m0_cti_i(m_cti[0]), .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
    .m1_adr_i(m_adr[1]), .m1_dat_i(m_dat[1]), .m1_sel_i(m_sel[1]), .m1_we_i(m_we[1]),
    .m1_bte_i(m_bte[1]), .m1_cti_i(m_cti[1]), .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_bte_o(s_bte_o), .s_cti_o(s_cti_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
    .gnt_o(gnt_o)
  );

  int n_checks = 0;
  int n_errs   = 0;

  // Reference model: current bus owner (-1 none), most recent owner, stall run length.
  int own      = -1;
  int last_own = 1;
  int stall    = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clear_bus();
    for (int k = 0; k < 2; k++) begin
      m_adr[k] = '0; m_dat[k] = '0; m_sel[k] = 4'hF; m_we[k] = 1'b0;
      m_bte[k] = 2'b00; m_cti[k] = 3'b000; m_cyc[k] = 1'b0; m_stb[k] = 1'b0;
    end
    s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
  endtask

  function automatic logic stalled_now();
    if (own < 0) return 1'b0;
    return m_stb[own] && !s_ack_i && !s_err_i && !s_rty_i;
  endfunction

  function automatic logic fire_now();
`ifdef WB_RAM_ARBITER_WATCHDOG_EN
    return stalled_now() && (stall == WD - 1);
`else
    return 1'b0;
`endif
  endfunction

  // Called at posedge+1 with inputs set: check mid-cycle, then advance the model at the edge.
  task automatic step();
    int    idx;
    int    nxt;
    logic  g, fire, stl;
    #4;
    g    = (own >= 0);
    idx  = (own == 1) ? 1 : 0;
    fire = fire_now();
    stl  = stalled_now();
    check_eq("gnt", gnt_o, (own == 0) ? 2'b01 : (own == 1) ? 2'b10 : 2'b00);
    check_eq("s_cyc", s_cyc_o, g ? m_cyc[idx] : 1'b0);
    check_eq("s_stb", s_stb_o, g ? (m_stb[idx] & ~fire) : 1'b0);
    check_eq("s_we", s_we_o, g ? m_we[idx] : 1'b0);
    check_eq("s_cti", s_cti_o, g ? m_cti[idx] : 3'b000);
    check_eq("s_adr", s_adr_o, m_adr[idx]);
    check_eq("s_dat", s_dat_o, m_dat[idx]);
    check_eq("s_sel", s_sel_o, m_sel[idx]);
    check_eq("s_bte", s_bte_o, m_bte[idx]);
    check_eq("m0_ack", m0_ack_o, (own == 0) & s_ack_i);
    check_eq("m0_err", m0_err_o, (own == 0) & (s_err_i | fire));
    check_eq("m0_rty", m0_rty_o, (own == 0) & s_rty_i);
    check_eq("m1_ack", m1_ack_o, (own == 1) & s_ack_i);
    check_eq("m1_err", m1_err_o, (own == 1) & (s_err_i | fire));
    check_eq("m1_rty", m1_rty_o, (own == 1) & s_rty_i);
    check_eq("m0_dat", m0_dat_o, s_dat_i);
    check_eq("m1_dat", m1_dat_o, s_dat_i);
    @(posedge clk);
    nxt = own;
    if (own < 0) begin
      if (m_cyc[0] && m_cyc[1]) nxt = (last_own == 1) ? 0 : 1;
      else if (m_cyc[0]) nxt = 0;
      else if (m_cyc[1]) nxt = 1;
    end else if (!m_cyc[own]) begin
      nxt = m_cyc[1 - own] ? 1 - own : -1;
    end
    stall = (!stl || fire || nxt != own) ? 0 : stall + 1;
    own = nxt;
    if (own >= 0) last_own = own;
    #1;
  endtask

  // Asserts reset off the clock edge; leaves time at posedge+1 with reset released.
  task automatic reset_dut();
    rst_n = 1'b0;
    #1;
    check_eq("rst_gnt", gnt_o, 2'b00);
    check_eq("rst_s_cyc", s_cyc_o, 1'b0);
    check_eq("rst_s_stb", s_stb_o, 1'b0);
    check_eq("rst_m0_ack", m0_ack_o, 1'b0);
    check_eq("rst_m1_ack", m1_ack_o, 1'b0);
    own = -1; last_own = 1; stall = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [31:0] wrap_adr [4];

  initial begin
    wrap_adr[0] = 32'h1C; wrap_adr[1] = 32'h10; wrap_adr[2] = 32'h14; wrap_adr[3] = 32'h18;
    clear_bus();
    s_ack_i = 1'b1;
    m_cyc[0] = 1'b1; m_cyc[1] = 1'b1;
    reset_dut();

    // Single classic read by m0.
    clear_bus();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[0] = 32'h10; s_ack_i = 1'b1; s_dat_i = 32'hCAFE_0010;
    step(); step();
    clear_bus(); step();

    // Simultaneous requests alternate, with direct hand-over.
    reset_dut();
    clear_bus();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_adr[1] = 32'h44;
    step(); step(); step();
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    step(); step();
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    step();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    step(); step();
    clear_bus(); step(); step(); step();

    // m1 wrap-4 burst with m0 requesting mid-burst.
    clear_bus();
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_cti[1] = 3'b010; m_bte[1] = 2'b01; m_adr[1] = wrap_adr[0];
    s_ack_i = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      m_adr[1] = wrap_adr[i];
      m_cti[1] = (i == 3) ? 3'b111 : 3'b010;
      if (i == 1) begin m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[0] = 32'h80; end
      step();
    end
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    step(); step();
    clear_bus(); step(); step();

    // Reset during beat 2 of an m1 burst.
    clear_bus();
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_cti[1] = 3'b010; s_ack_i = 1'b1;
    step(); step();
    #2;
    check_eq("pre_rst_m1_ack", m1_ack_o, 1'b1);
    reset_dut();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    step(); step();
    clear_bus(); step(); step();

    // Slave error on out-of-range address.
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[0] = 32'h0001_0000; s_err_i = 1'b1;
    step(); step();
    clear_bus(); step(); step();

`ifdef WB_RAM_ARBITER_WATCHDOG_EN
    // Slave never answers m0; m1 waits behind it.
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    step();
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 7) begin
        #4;
        check_eq("wd_err_8th", m0_err_o, 1'b1);
        #1;
        own = own; // keep alignment: remaining half-cycle handled by step below
        #(-0);
        #0;
        // re-align to posedge+1 timing expected by step()
        @(posedge clk); #1;
        stall = 0;
      end else begin
        step();
      end
    end
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0; s_ack_i = 1'b1;
    step(); step();
    clear_bus(); step(); step();
`endif

    // Random traffic.
    clear_bus();
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < 2; k++) begin
        if (m_cyc[k]) begin
          if ($urandom_range(0, 5) == 0) m_cyc[k] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          m_cyc[k] = 1'b1;
        end
        m_stb[k] = m_cyc[k] & 1'($urandom_range(0, 1));
        m_adr[k] = $urandom;
        m_dat[k] = $urandom;
        m_sel[k] = 4'($urandom_range(0, 15));
        m_we[k]  = 1'($urandom_range(0, 1));
        m_bte[k] = 2'($urandom_range(0, 3));
        m_cti[k] = 3'($urandom_range(0, 7));
      end
      s_dat_i = $urandom;
      s_ack_i = ($urandom_range(0, 2) == 0);
      s_err_i = ($urandom_range(0, 15) == 0);
      s_rty_i = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
